// File: rtl/display_mux_scheduler_pkg.sv
// Shared types and defaults for the two-digit display multiplexer.
// Holds the mux state encoding and the default refresh/blanking timing.
package display_pkg;

   typedef enum logic [1:0] {
      SHOW_R   = 2'd0,
      BLANK_RL = 2'd1,
      SHOW_L   = 2'd2,
      BLANK_LR = 2'd3
   } mux_state_t;

   localparam int DEFAULT_REFRESH_DIV  = 24000;
   localparam int DEFAULT_BLANK_CYCLES = 480;
   localparam int DIGIT_W              = 4;

endpackage

// File: rtl/display_mux_scheduler_refresh_timer.sv
// Loadable down-counter that flags when it has reached zero.
// It holds at zero until the next load.
module refresh_timer #(
   parameter int              WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RESET_VAL;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/display_mux_scheduler.sv
// Time-multiplexes one seven-segment decoder between a left and right digit,
// with a blanking gap between anode switches and a two-entry key history.
module display_mux_scheduler
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
   parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               key_valid,
   input  logic [DIGIT_W-1:0] key_digit,
   output logic [DIGIT_W-1:0] seg_digit,
   output logic               en_left,
   output logic               en_right,
   output logic [DIGIT_W-1:0] digit_left,
   output logic [DIGIT_W-1:0] digit_right,
   output logic               key_accepted
);

   localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int TW      = ($clog2(MAX_CNT) < 1) ? 1 : $clog2(MAX_CNT);
   localparam logic [TW-1:0] SHOW_LOAD  = TW'(REFRESH_DIV - 1);
   localparam logic [TW-1:0] BLANK_LOAD = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam bit SKIP_BLANK = (BLANK_CYCLES == 0);

   mux_state_t         state_q, state_d;
   logic               timer_zero;
   logic [TW-1:0]      load_val;
   logic               key_valid_q;
   logic               capture;
   logic [DIGIT_W-1:0] digit_left_q, digit_right_q;
   logic               key_accepted_q;

   // Reset loads the first SHOW period directly so SHOW_R lasts REFRESH_DIV cycles.
   refresh_timer #(
      .WIDTH     (TW),
      .RESET_VAL (SHOW_LOAD)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_zero),
      .load_val (load_val),
      .zero     (timer_zero)
   );

   always_comb begin
      state_d = state_q;
      if (timer_zero) begin
         case (state_q)
            SHOW_R:   state_d = SKIP_BLANK ? SHOW_L : BLANK_RL;
            BLANK_RL: state_d = SHOW_L;
            SHOW_L:   state_d = SKIP_BLANK ? SHOW_R : BLANK_LR;
            BLANK_LR: state_d = SHOW_R;
            default:  state_d = SHOW_R;
         endcase
      end
   end

   assign load_val = ((state_d == SHOW_R) || (state_d == SHOW_L)) ? SHOW_LOAD : BLANK_LOAD;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SHOW_R;
      end else begin
         state_q <= state_d;
      end
   end

   // Only the rising edge of key_valid captures, so a held key counts once.
   assign capture = key_valid & ~key_valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         key_valid_q    <= 1'b0;
         digit_left_q   <= '0;
         digit_right_q  <= '0;
         key_accepted_q <= 1'b0;
      end else begin
         key_valid_q    <= key_valid;
         key_accepted_q <= capture;
         if (capture) begin
            digit_left_q  <= digit_right_q;
            digit_right_q <= key_digit;
         end
      end
   end

   // Blank states already present the upcoming digit so the decoder settles early.
   always_comb begin
      en_left   = 1'b0;
      en_right  = 1'b0;
      seg_digit = digit_right_q;
      case (state_q)
         SHOW_R: begin
            en_right  = 1'b1;
            seg_digit = digit_right_q;
         end
         BLANK_RL: seg_digit = digit_left_q;
         SHOW_L: begin
            en_left   = 1'b1;
            seg_digit = digit_left_q;
         end
         BLANK_LR: seg_digit = digit_right_q;
         default:  seg_digit = digit_right_q;
      endcase
   end

   assign digit_left   = digit_left_q;
   assign digit_right  = digit_right_q;
   assign key_accepted = key_accepted_q;

endmodule
